// File: rtl/serial_comparator_if.sv
// rtl/serial_comparator_if.sv - start/busy/done request bus of the bit-serial comparator
interface serial_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [1:0]       out;

  modport master (
    output start, a, b,
    input  busy, done, out
  );

  modport slave (
    input  start, a, b,
    output busy, done, out
  );
endinterface

// File: rtl/serial_comparator.sv
// rtl/serial_comparator.sv - MSB-first bit-serial unsigned magnitude comparator, out = {eq, gt}
// Optional SERIAL_COMPARATOR_EARLY_EXIT_EN: finish on the first differing bit instead of after WIDTH bits.
module serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_comparator_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  generate
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("serial_comparator: WIDTH must be in 2..64");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sa_n;
  logic [WIDTH-1:0] sb, sb_n;
  logic             eq, eq_n;
  logic             gt, gt_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [1:0]       out_q, out_n;

  logic             bit_a, bit_b;
  logic             diff;
  logic             eq_step, gt_step;
  logic             scan_exit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      eq    <= 1'b1;
      gt    <= 1'b0;
      cnt   <= '0;
      out_q <= 2'b00;
    end else begin
      state <= state_n;
      sa    <= sa_n;
      sb    <= sb_n;
      eq    <= eq_n;
      gt    <= gt_n;
      cnt   <= cnt_n;
      out_q <= out_n;
    end
  end

  // Only the first differing bit may change the verdict; later bits are ignored once eq drops.
  always_comb begin
    bit_a   = sa[WIDTH-1];
    bit_b   = sb[WIDTH-1];
    diff    = eq && (bit_a != bit_b);
    eq_step = eq && !diff;
    gt_step = diff ? (bit_a & ~bit_b) : gt;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    scan_exit = (cnt == '0) || diff;
`else
    scan_exit = (cnt == '0);
`endif
  end

  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    eq_n    = eq;
    gt_n    = gt;
    cnt_n   = cnt;
    out_n   = out_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          sa_n    = bus.a;
          sb_n    = bus.b;
          eq_n    = 1'b1;
          gt_n    = 1'b0;
          cnt_n   = CW'(WIDTH - 1);
          state_n = SCAN;
        end
      end

      SCAN: begin
        sa_n  = sa << 1;
        sb_n  = sb << 1;
        eq_n  = eq_step;
        gt_n  = gt_step;
        cnt_n = cnt - 1'b1;
        if (scan_exit) begin
          out_n   = {eq_step, gt_step};
          state_n = DONE;
        end
      end

      DONE: begin
        // The edge leaving DONE doubles as the next accepting edge, giving one result per WIDTH+1 cycles.
        if (bus.start) begin
          sa_n    = bus.a;
          sb_n    = bus.b;
          eq_n    = 1'b1;
          gt_n    = 1'b0;
          cnt_n   = CW'(WIDTH - 1);
          state_n = SCAN;
        end else begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.out  = out_q;
endmodule

// File: tb/tb_serial_comparator.sv
// tb/tb_serial_comparator.sv - directed scoreboard bench for serial_comparator
module tb_serial_comparator;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_comparator_if #(.WIDTH(W)) bus ();

  serial_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] out;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   dbl_done = 0;
  int   stray_out = 0;
  logic       prev_done = 1'b0;
  logic [1:0] prev_out = 2'b00;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.done && prev_done) dbl_done++;
      if (!bus.done && bus.out !== prev_out) stray_out++;
    end
    prev_done = bus.done;
    prev_out  = bus.out;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_out(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == y) return 2'b10;
    if (x > y)  return 2'b01;
    return 2'b00;
  endfunction

  function automatic int lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) if (x[i] != y[i]) return W - i;
`endif
    return W;
  endfunction

  // Called just after a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    exp_t e;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    @(negedge clk);
    e.out = ref_out(x, y);
    e.cyc = cyc + lat(x, y);
    sb.push_back(e);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int n = 0;
    while (!bus.done && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, bus.done, 1);
    chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (bus.done && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_out"}, bus.out, e.out);
      chk({tag, "_cycle"}, cyc, e.cyc);
    end
  endtask

  initial begin
    int first_cyc, n_done;
    exp_t e;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_out", bus.out, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'h5A, 8'h5A, 0);
    chk("eq_busy_rise", bus.busy, 1);
    wait_done("eq");
    @(negedge clk);
    chk("eq_busy_fall", bus.busy, 0);
    chk("eq_done_fall", bus.done, 0);
    chk("eq_out_hold", bus.out, 2'b10);

    issue(8'hF0, 8'h0F, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_out", bus.out, 2'b00);
    sb.delete();
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.done) n_done++;
    chk("rst_no_done", n_done, 0);
    issue(8'h01, 8'h01, 0);
    wait_done("post_rst_eq");
    @(negedge clk);

    issue(8'h80, 8'h7F, 0);
    wait_done("msb_gt");
    @(negedge clk);

    issue(8'h03, 8'h04, 0);
    wait_done("low_lt");
    @(negedge clk);

    issue(8'hFF, 8'hFE, 0);
    wait_done("lsb_gt");
    @(negedge clk);

    issue(8'h00, 8'hFF, 0);
    wait_done("zero_lt");
    @(negedge clk);

    issue(8'h10, 8'h20, 0);
    repeat (2) @(negedge clk);
    bus.a = 8'hFF;
    bus.b = 8'h00;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_start");
    n_done = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    chk("busy_start_single", n_done, 0);
    chk("busy_start_idle", bus.busy, 0);
    chk("busy_start_out", bus.out, 2'b00);

    issue(8'h01, 8'h02, 1);
    bus.a = 8'h02;
    bus.b = 8'h01;
    wait_done("b2b_first");
    first_cyc = cyc;
    e.out = ref_out(8'h02, 8'h01);
    e.cyc = cyc + 1 + lat(8'h02, 8'h01);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy_held", bus.busy, 1);
    wait_done("b2b_second");
    chk("b2b_gap", cyc - first_cyc, 1 + lat(8'h02, 8'h01));
    repeat (2) @(negedge clk);

    chk("no_double_done", dbl_done, 0);
    chk("no_stray_out", stray_out, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
